// File: rtl/sync_pkg.sv
// Constants shared by the reset synchroniser and the bus synchroniser.
package sync_pkg;

  localparam int SYNC_DEFAULT_STAGES = 2;
  localparam int SYNC_MIN_STAGES     = 2;

  // Fewer than two flops gives no metastability settling time.
  function automatic bit stages_ok(input int num_stages);
    return num_stages >= SYNC_MIN_STAGES;
  endfunction

endpackage

// File: rtl/data_bus_sync_if.sv
// Bus-crossing signals between a foreign-domain source and data_bus_sync.
// ACK_TOGGLE exists only when DATA_BUS_SYNC_ACK_EN is defined.
interface data_bus_sync_if #(
  parameter int BUS_WIDTH = 8
);

  // BUS_ENABLE is a level qualifier, not a valid/ready pair. The source raises
  // it with UNSYNC_BUS already stable and holds both until the receiver has
  // pulsed ENABLE_PULSE. There is no backpressure, and each rising edge of
  // BUS_ENABLE yields exactly one ENABLE_PULSE with SYNC_BUS updated.
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 BUS_ENABLE;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 ENABLE_PULSE;
`ifdef DATA_BUS_SYNC_ACK_EN
  logic                 ACK_TOGGLE;

  modport master (
    output UNSYNC_BUS, BUS_ENABLE,
    input  SYNC_BUS, ENABLE_PULSE, ACK_TOGGLE
  );
  modport slave (
    input  UNSYNC_BUS, BUS_ENABLE,
    output SYNC_BUS, ENABLE_PULSE, ACK_TOGGLE
  );
`else
  modport master (
    output UNSYNC_BUS, BUS_ENABLE,
    input  SYNC_BUS, ENABLE_PULSE
  );
  modport slave (
    input  UNSYNC_BUS, BUS_ENABLE,
    output SYNC_BUS, ENABLE_PULSE
  );
`endif

endinterface

// File: rtl/bit_sync.sv
// NUM_STAGES-deep single-bit synchroniser with asynchronous active-low reset.
module bit_sync
  import sync_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_DEFAULT_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (!stages_ok(NUM_STAGES)) begin : g_stage_check
    $error("bit_sync: NUM_STAGES must be at least SYNC_MIN_STAGES");
  end

  logic [NUM_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], d};
    end
  end

  assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_bus_sync.sv
// Multi-bit CDC receiver: synchronised BUS_ENABLE edge captures UNSYNC_BUS once.
// Optional ACK_TOGGLE output is enabled by defining DATA_BUS_SYNC_ACK_EN.
module data_bus_sync
  import sync_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_DEFAULT_STAGES,
  parameter int BUS_WIDTH  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  data_bus_sync_if.slave bus
);

  logic                 en_sync_last;
  logic                 en_q;
  logic                 pulse_det;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic                 enable_pulse_q;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_sync (
    .clk  (CLK),
    .rst_n(RST),
    .d    (bus.BUS_ENABLE),
    .q    (en_sync_last)
  );

  // The bus itself is never synchronised: it is sampled only on the
  // qualifier's rising edge, when the source guarantees it is stable.
  assign pulse_det = en_sync_last & ~en_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q           <= 1'b0;
      sync_bus_q     <= '0;
      enable_pulse_q <= 1'b0;
    end else begin
      en_q           <= en_sync_last;
      enable_pulse_q <= pulse_det;
      if (pulse_det) begin
        sync_bus_q <= bus.UNSYNC_BUS;
      end
    end
  end

  assign bus.SYNC_BUS     = sync_bus_q;
  assign bus.ENABLE_PULSE = enable_pulse_q;

`ifdef DATA_BUS_SYNC_ACK_EN
  logic ack_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_q <= 1'b0;
    end else if (pulse_det) begin
      ack_q <= ~ack_q;
    end
  end

  assign bus.ACK_TOGGLE = ack_q;
`endif

endmodule

// File: tb/tb_data_bus_sync.sv
// Self-checking bench for data_bus_sync with NUM_STAGES=2 and NUM_STAGES=4 instances.
module tb_data_bus_sync;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] data;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q4[$];
  logic         mon_on = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  data_bus_sync_if #(.BUS_WIDTH(W)) bus2 ();
  data_bus_sync_if #(.BUS_WIDTH(W)) bus4 ();

  assign bus2.UNSYNC_BUS = data;
  assign bus2.BUS_ENABLE = en;
  assign bus4.UNSYNC_BUS = data;
  assign bus4.BUS_ENABLE = en;

  data_bus_sync #(.NUM_STAGES(2), .BUS_WIDTH(W)) dut2 (
    .CLK(clk), .RST(rst_n), .bus(bus2)
  );
  data_bus_sync #(.NUM_STAGES(4), .BUS_WIDTH(W)) dut4 (
    .CLK(clk), .RST(rst_n), .bus(bus4)
  );

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic p2, input logic [W-1:0] b2,
                         input logic p4, input logic [W-1:0] b4);
    chk({tag, ".pulse2"}, W'(bus2.ENABLE_PULSE), W'(p2));
    chk({tag, ".bus2"},   bus2.SYNC_BUS,         b2);
    chk({tag, ".pulse4"}, W'(bus4.ENABLE_PULSE), W'(p4));
    chk({tag, ".bus4"},   bus4.SYNC_BUS,         b4);
  endtask

  task automatic chk_ack(input string tag, input logic a);
`ifdef DATA_BUS_SYNC_ACK_EN
    chk({tag, ".ack2"}, W'(bus2.ACK_TOGGLE), W'(a));
`else
    if (a === 1'bx) $display("unreachable");
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) tick();
  endtask

  // Reset just released with en high: chain refills, pulse at t=NUM_STAGES.
  task automatic release_seq(input string tag, input logic [W-1:0] d);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk_all(tag, (t == 2), (t >= 2) ? d : '0, (t == 4), (t >= 4) ? d : '0);
      chk_ack(tag, (t >= 2));
    end
  endtask

  // Source domain delay that never lands on an active clock edge.
  task automatic src_wait(input int sp);
    #(sp);
    if (($time % 10) == 5) #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (bus2.ENABLE_PULSE) begin
          chk("sb2_nonempty", W'(exp_q2.size() != 0), W'(1'b1));
          if (exp_q2.size() != 0) chk("sb2_data", bus2.SYNC_BUS, exp_q2.pop_front());
        end
        if (bus4.ENABLE_PULSE) begin
          chk("sb4_nonempty", W'(exp_q4.size() != 0), W'(1'b1));
          if (exp_q4.size() != 0) chk("sb4_data", bus4.SYNC_BUS, exp_q4.pop_front());
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         en;
    logic [W-1:0] data;
    logic         p2;
    logic [W-1:0] b2;
    logic         p4;
    logic [W-1:0] b4;
    logic         ack2;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [W-1:0] d, input logic p2,
                              input logic [W-1:0] b2, input logic p4,
                              input logic [W-1:0] b4, input logic a);
    vec_t v;
    v.en = e; v.data = d; v.p2 = p2; v.b2 = b2; v.p4 = p4; v.b4 = b4; v.ack2 = a;
    return v;
  endfunction

  vec_t vecs[27];

  // ---------------- main test ----------------
  initial begin
    int n2, n4, sp, hi;
    logic [W-1:0] d;

    // Single 0x3C transfer, high 5 cycles, low 5
    vecs[0]  = mk(1, 8'h3C, 0, 8'hA5, 0, 8'hA5, 1);
    vecs[1]  = mk(1, 8'h3C, 0, 8'hA5, 0, 8'hA5, 1);
    vecs[2]  = mk(1, 8'h3C, 1, 8'h3C, 0, 8'hA5, 0);
    vecs[3]  = mk(1, 8'h3C, 0, 8'h3C, 0, 8'hA5, 0);
    vecs[4]  = mk(1, 8'h3C, 0, 8'h3C, 1, 8'h3C, 0);
    for (int i = 5; i < 10; i++) vecs[i] = mk(0, 8'h3C, 0, 8'h3C, 0, 8'h3C, 0);
    // 0x11 then 0xEE, 3 high / 3 low each, then settle
    vecs[10] = mk(1, 8'h11, 0, 8'h3C, 0, 8'h3C, 0);
    vecs[11] = mk(1, 8'h11, 0, 8'h3C, 0, 8'h3C, 0);
    vecs[12] = mk(1, 8'h11, 1, 8'h11, 0, 8'h3C, 1);
    vecs[13] = mk(0, 8'h11, 0, 8'h11, 0, 8'h3C, 1);
    vecs[14] = mk(0, 8'h11, 0, 8'h11, 1, 8'h11, 1);
    vecs[15] = mk(0, 8'h11, 0, 8'h11, 0, 8'h11, 1);
    vecs[16] = mk(1, 8'hEE, 0, 8'h11, 0, 8'h11, 1);
    vecs[17] = mk(1, 8'hEE, 0, 8'h11, 0, 8'h11, 1);
    vecs[18] = mk(1, 8'hEE, 1, 8'hEE, 0, 8'h11, 0);
    vecs[19] = mk(0, 8'hEE, 0, 8'hEE, 0, 8'h11, 0);
    vecs[20] = mk(0, 8'hEE, 0, 8'hEE, 1, 8'hEE, 0);
    for (int i = 21; i < 27; i++) vecs[i] = mk(0, 8'hEE, 0, 8'hEE, 0, 8'hEE, 0);

    // Reset held with BUS_ENABLE high
    rst_n = 1'b0;
    en    = 1'b1;
    data  = 8'hA5;
    #1;
    chk_all("rst_en_hi", 0, '0, 0, '0);
    chk_ack("rst_en_hi", 0);
    repeat (3) begin
      tick();
      chk_all("rst_hold", 0, '0, 0, '0);
    end
    rst_n = 1'b1;
    release_seq("rst_release", 8'hA5);
    idle(6);

    // Table-driven vectors
    for (int i = 0; i < 27; i++) begin
      en   = vecs[i].en;
      data = vecs[i].data;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].p2, vecs[i].b2, vecs[i].p4, vecs[i].b4);
      chk_ack($sformatf("vec%0d", i), vecs[i].ack2);
    end

    // Level held 50 cycles, bus changes after the pulse
    n2   = 0;
    n4   = 0;
    en   = 1'b1;
    data = 8'h5A;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus2.ENABLE_PULSE) n2++;
      if (bus4.ENABLE_PULSE) n4++;
      if (c >= 5) data = W'($urandom_range(0, 255));
    end
    en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus2.ENABLE_PULSE) n2++;
      if (bus4.ENABLE_PULSE) n4++;
    end
    chk("hold_pulses2", W'(n2), W'(1));
    chk("hold_pulses4", W'(n4), W'(1));
    chk("hold_bus2", bus2.SYNC_BUS, 8'h5A);
    chk("hold_bus4", bus4.SYNC_BUS, 8'h5A);
    chk_ack("hold", 1);

    // Reset asserted mid-chain, BUS_ENABLE still high at release
    data = 8'hC3;
    en   = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all("midrst_async", 0, '0, 0, '0);
    chk_ack("midrst_async", 0);
    repeat (3) begin
      tick();
      chk_all("midrst_hold", 0, '0, 0, '0);
    end
    rst_n = 1'b1;
    release_seq("midrst_release", 8'hC3);
    idle(8);

    // Random source-clock ratio, compliant timing, scoreboard in order
    mon_on = 1'b1;
    for (int x = 0; x < 12; x++) begin
      sp = $urandom_range(3, 30);
      hi = (60 + sp - 1) / sp + 1;
      d  = W'($urandom_range(0, 255));
      src_wait(sp);
      data = d;
      en   = 1'b1;
      exp_q2.push_back(d);
      exp_q4.push_back(d);
      repeat (hi) src_wait(sp);
      en = 1'b0;
      repeat (hi) src_wait(sp);
    end
    repeat (10) tick();
    mon_on = 1'b0;
    chk("sb2_drained", W'(exp_q2.size()), W'(0));
    chk("sb4_drained", W'(exp_q4.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_sync.md
# data_bus_sync

Multi-bit clock-domain-crossing receiver that transfers a data bus launched in a foreign clock domain into the local `CLK` domain. It uses a qualifier (`BUS_ENABLE`) synchronised through a flop chain, then rising-edge detected. Its `RST` is driven by the local reset synchroniser's `SYNC_RST`, so it sits directly downstream of the reset-sync stage in every clock domain that receives a bus (e.g. UART TX data into the UART clock domain). It delivers a stable captured bus plus a single-cycle `ENABLE_PULSE` to the consuming logic.

## Interface
- `NUM_STAGES`, 2, flops in the `BUS_ENABLE` synchroniser chain; legal range ≥ 2.
- `BUS_WIDTH`, 8, width of the transferred bus; legal range ≥ 1.
- `CLK`  in  1  destination-domain clock; all state is on its rising edge.
- `RST`  in  1  reset, asynchronous and active-low (one clock; polarity and synchronicity fixed); driven from the domain's synchronised reset.
- `UNSYNC_BUS`  in  `BUS_WIDTH`  source-domain data; must be stable while `BUS_ENABLE` is high.
- `BUS_ENABLE`  in  1  source-domain qualifier level; asynchronous to `CLK`.
- `SYNC_BUS`  out  `BUS_WIDTH`  captured data, registered.
- `ENABLE_PULSE`  out  1  one-cycle strobe marking a new `SYNC_BUS` value, registered.
- `ACK_TOGGLE`  out  1  capture acknowledge toggle; present only with `DATA_BUS_SYNC_ACK_EN`.

## Operation
- `BUS_ENABLE` passes through `NUM_STAGES` flops (`en_sync`); the last stage feeds `en_q`, one extra flop.
- Rising-edge detect: `pulse_det = en_sync[NUM_STAGES-1] & ~en_q`.
- On `pulse_det`:
  - `SYNC_BUS <= UNSYNC_BUS`.
  - `ENABLE_PULSE <= 1`.
- Otherwise:
  - `SYNC_BUS` holds.
  - `ENABLE_PULSE <= 0`.
- `UNSYNC_BUS` is never synchronised bitwise. It is sampled only when `pulse_det` is set, when the source guarantees stability.
- One capture per `BUS_ENABLE` rising edge. A level held high for any duration yields exactly one pulse.
- Reset (async assert, any cycle): `en_sync`, `en_q`, `SYNC_BUS`, `ENABLE_PULSE` and `ACK_TOGGLE` all go to 0. An in-flight transfer is discarded; no pulse is emitted for it.
- If `BUS_ENABLE` is already high at reset release, the chain refills from 0. This is treated as a new edge: one pulse and one capture occur `NUM_STAGES` cycles after the first sampling edge.

## Timing
- Latency: `BUS_ENABLE` first sampled high at edge k → `SYNC_BUS` valid and `ENABLE_PULSE` high after edge k+`NUM_STAGES`, for exactly one cycle.
- Source obligations:
  - `BUS_ENABLE` high for ≥ `NUM_STAGES`+1 `CLK` cycles.
  - `UNSYNC_BUS` stable from `BUS_ENABLE` rise until ≥1 cycle after `ENABLE_PULSE`.
  - `BUS_ENABLE` low for ≥ `NUM_STAGES`+1 cycles between transfers.
- Violations:
  - Low gap too short: the second edge may be merged and lost. No error is flagged.
  - Glitch shorter than one cycle: may or may not produce a pulse. Either outcome is acceptable.
- `ENABLE_PULSE` is never high in two consecutive cycles.
- `SYNC_BUS` changes only in the cycle `ENABLE_PULSE` rises.

## Configuration
- `DATA_BUS_SYNC_ACK_EN` defined:
  - Adds the `ACK_TOGGLE` output, reset 0.
  - `ACK_TOGGLE` inverts on the same edge that raises `ENABLE_PULSE`.
  - The source domain resynchronises it as a four-phase-free completion indication.
- Undefined: the port and its flop are absent; behaviour is otherwise identical.

## Structure
- Shared package `sync_pkg`:
  - `SYNC_DEFAULT_STAGES = 2`.
  - `SYNC_MIN_STAGES = 2`.
  - Elaboration check that `NUM_STAGES >= SYNC_MIN_STAGES`.
  - Reused by the reset synchroniser and this block.
- One sub-module: `bit_sync` (`NUM_STAGES`-deep single-bit synchroniser, async active-low reset), instantiated for `BUS_ENABLE`.
- Edge detect, capture register and ack toggle stay in the top.

## Test plan
- Reset asserted with `BUS_ENABLE`=1 and `UNSYNC_BUS`=0xA5 → all outputs 0 during reset. After release, one `ENABLE_PULSE` and `SYNC_BUS`=0xA5 exactly 2 cycles after the first sampling edge (`NUM_STAGES`=2).
- `UNSYNC_BUS`=0x3C, `BUS_ENABLE` high for 5 cycles → `SYNC_BUS`=0x3C at k+2, `ENABLE_PULSE` high 1 cycle only. Repeat with `NUM_STAGES`=4 → k+4.
- Two transfers 0x11 then 0xEE, each with 3-cycle high and 3-cycle low gaps → exactly two pulses, `SYNC_BUS` 0x11 then 0xEE. `ACK_TOGGLE` goes 0→1→0 when the macro is defined.
- `BUS_ENABLE` held high 50 cycles while `UNSYNC_BUS` changes after the pulse → single pulse; `SYNC_BUS` keeps the first captured value.
- Reset asserted 1 cycle after `BUS_ENABLE` rise (mid-chain) → outputs 0, no pulse during reset. After release with `BUS_ENABLE` still high → one pulse at release+2.
- Randomised source-clock ratio (0.3×–3×) with compliant timing → every transfer captured once, in order, with no corruption.
